// File: rtl/control_setare.sv
// Time/alarm setting sequencer for the alarm clock: turns debounced mode/increment buttons
// into edit values, setting flags and one-cycle load strobes for the time counter and alarm.
//
// state   | meaning
// --------+-----------------------------------------------
// NORMAL  | not editing, buttons only watched for mode
// T_ORE   | editing clock hours
// T_MIN   | editing clock minutes
// SCRIE_T | one-cycle commit of the edited time
// A_ORE   | editing alarm hours
// A_MIN   | editing alarm minutes
// SCRIE_A | one-cycle commit of the edited alarm
module control_setare #(
   parameter int unsigned REPEAT_DELAY = 50_000_000,
   parameter int unsigned REPEAT_RATE  = 12_500_000,
   parameter int unsigned TIMEOUT      = 500_000_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_mod,
   input  logic       btn_inc,
   input  logic [5:0] minute,
   input  logic [4:0] ore,
   input  logic [5:0] minute_alarma,
   input  logic [4:0] ore_alarma,
   output logic [5:0] minute_setare,
   output logic [4:0] ore_setare,
   output logic       semnal_setare,
   output logic       semnal_setare_a,
   output logic       camp_ore,
   output logic       incarca_timp,
   output logic       incarca_alarma
);

   typedef enum logic [2:0] {
      NORMAL, T_ORE, T_MIN, SCRIE_T, A_ORE, A_MIN, SCRIE_A
   } state_t;

   localparam logic [31:0] DELAY_C   = 32'(REPEAT_DELAY);
   localparam logic [31:0] RATE_C    = 32'(REPEAT_RATE);
   localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);

   state_t      state, state_nxt;
   logic        btn_mod_q, btn_inc_q;
   logic        mod_edge, inc_edge;
   logic        rep_armed, rep_fire, incr;
   logic        in_edit, idle_expire;
   logic [31:0] rep_cnt, rep_cnt_inc, rep_target;
   logic [31:0] idle_cnt, idle_cnt_inc;

   always_comb begin
      mod_edge     = btn_mod & ~btn_mod_q;
      inc_edge     = btn_inc & ~btn_inc_q;
      rep_cnt_inc  = rep_cnt + 32'd1;
      // first repeat waits the long delay, later ones use the shorter rate
      rep_target   = rep_armed ? RATE_C : DELAY_C;
      rep_fire     = btn_inc & ~inc_edge & (rep_cnt_inc == rep_target);
      incr         = inc_edge | rep_fire;
      in_edit      = (state == T_ORE) || (state == T_MIN) ||
                     (state == A_ORE) || (state == A_MIN);
      idle_cnt_inc = idle_cnt + 32'd1;
      idle_expire  = in_edit & ~mod_edge & ~incr & (idle_cnt_inc == TIMEOUT_C);

      state_nxt = state;
      case (state)
         NORMAL:  if (mod_edge) state_nxt = T_ORE;
         T_ORE:   if (mod_edge) state_nxt = T_MIN;
                  else if (idle_expire) state_nxt = NORMAL;
         T_MIN:   if (mod_edge) state_nxt = SCRIE_T;
                  else if (idle_expire) state_nxt = NORMAL;
         SCRIE_T: state_nxt = A_ORE;
         A_ORE:   if (mod_edge) state_nxt = A_MIN;
                  else if (idle_expire) state_nxt = NORMAL;
         A_MIN:   if (mod_edge) state_nxt = SCRIE_A;
                  else if (idle_expire) state_nxt = NORMAL;
         SCRIE_A: state_nxt = NORMAL;
         default: state_nxt = NORMAL;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= NORMAL;
         btn_mod_q       <= 1'b1;
         btn_inc_q       <= 1'b1;
         rep_cnt         <= '0;
         rep_armed       <= 1'b0;
         idle_cnt        <= '0;
         ore_setare      <= '0;
         minute_setare   <= '0;
         semnal_setare   <= 1'b0;
         semnal_setare_a <= 1'b0;
         camp_ore        <= 1'b0;
         incarca_timp    <= 1'b0;
         incarca_alarma  <= 1'b0;
      end else begin
         btn_mod_q <= btn_mod;
         btn_inc_q <= btn_inc;

         if (!btn_inc || inc_edge) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
         end else if (rep_fire) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b1;
         end else begin
            rep_cnt   <= rep_cnt_inc;
         end

         if (!in_edit || mod_edge || incr || idle_expire)
            idle_cnt <= '0;
         else
            idle_cnt <= idle_cnt_inc;

         // mode edge takes priority; a coincident increment is dropped
         if (state == NORMAL && mod_edge) begin
            ore_setare    <= ore;
            minute_setare <= minute;
         end else if (state == SCRIE_T) begin
            ore_setare    <= ore_alarma;
            minute_setare <= minute_alarma;
         end else if (!mod_edge && incr) begin
            if (state == T_ORE || state == A_ORE)
               ore_setare <= (ore_setare >= 5'd23) ? 5'd0 : ore_setare + 5'd1;
            else if (state == T_MIN || state == A_MIN)
               minute_setare <= (minute_setare >= 6'd59) ? 6'd0 : minute_setare + 6'd1;
         end

         state           <= state_nxt;
         semnal_setare   <= (state_nxt == T_ORE) || (state_nxt == T_MIN) || (state_nxt == SCRIE_T);
         semnal_setare_a <= (state_nxt == A_ORE) || (state_nxt == A_MIN) || (state_nxt == SCRIE_A);
         camp_ore        <= (state_nxt == T_ORE) || (state_nxt == A_ORE);
         incarca_timp    <= (state_nxt == SCRIE_T);
         incarca_alarma  <= (state_nxt == SCRIE_A);
      end
   end

endmodule

// File: doc/control_setare.md
# control_setare

Time/alarm setting controller for the alarm-clock design. It turns the debounced mode and increment buttons into a setting sequence: edit clock hours, edit clock minutes, commit the time, edit alarm hours, edit alarm minutes, commit the alarm. It drives the edit values and the setting flags read by `display`. It also issues one-cycle load strobes to the time counter and the alarm register.

## Interface

Parameters:
- `REPEAT_DELAY`, 50_000_000: cycles `btn_inc` must be held after its rising edge before auto-repeat starts (≥1).
- `REPEAT_RATE`, 12_500_000: cycles between auto-repeat increments (≥1).
- `TIMEOUT`, 500_000_000: idle cycles in an edit state before the edit is abandoned (≥1).
- All counters are 32 bits. Every parameter is < 2^32.

Ports:
- `clock`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `btn_mod`  in  1  mode button, debounced and synchronous, level.
- `btn_inc`  in  1  increment button, debounced and synchronous, level.
- `minute`  in  6  current clock minutes, 0–59.
- `ore`  in  5  current clock hours, 0–23.
- `minute_alarma`  in  6  current alarm minutes.
- `ore_alarma`  in  5  current alarm hours.
- `minute_setare`  out  6  minutes value being edited.
- `ore_setare`  out  5  hours value being edited.
- `semnal_setare`  out  1  high while the clock time is being edited.
- `semnal_setare_a`  out  1  high while the alarm is being edited.
- `camp_ore`  out  1  high while the hours field is selected (for blink).
- `incarca_timp`  out  1  one-cycle strobe: load `ore_setare`/`minute_setare` into the time counter.
- `incarca_alarma`  out  1  one-cycle strobe: load the edit values into the alarm register.

## Operation

- Edge detection:
  - `mod_edge = btn_mod & ~btn_mod_q`; `inc_edge` is defined the same way.
  - The `_q` registers reset to 1, so a button held through reset produces no edge.
- States and transitions:
  - NORMAL: on `mod_edge`, copy `ore`/`minute` into the edit registers and go to T_ORE.
  - T_ORE: `mod_edge` goes to T_MIN.
  - T_MIN: `mod_edge` goes to SCRIE_T.
  - SCRIE_T: one cycle, then A_ORE. On that transition, copy `ore_alarma`/`minute_alarma` into the edit registers.
  - A_ORE: `mod_edge` goes to A_MIN.
  - A_MIN: `mod_edge` goes to SCRIE_A.
  - SCRIE_A: one cycle, then NORMAL.
- Output decode (registered, derived from state):
  - `semnal_setare` = T_ORE, T_MIN or SCRIE_T.
  - `semnal_setare_a` = A_ORE, A_MIN or SCRIE_A.
  - `camp_ore` = T_ORE or A_ORE.
  - `incarca_timp` = SCRIE_T.
  - `incarca_alarma` = SCRIE_A.
- Increment:
  - In the ORE states, an increment does hours +1 with wrap 23→0.
  - In the MIN states, minutes +1 with wrap 59→0.
  - The other field is unchanged.
  - Increments are ignored in NORMAL and in the SCRIE states.
- Auto-repeat:
  - A repeat counter clears on `inc_edge`.
  - While `btn_inc` stays high, one extra increment fires when the count reaches `REPEAT_DELAY`, then one every `REPEAT_RATE` cycles.
  - Releasing `btn_inc` stops repeats immediately.
- Timeout:
  - An idle counter runs in the four edit states and clears on any `mod_edge`, `inc_edge` or repeat increment.
  - When it reaches `TIMEOUT`, go to NORMAL with no load strobe. The edit is discarded.
- Simultaneous `mod_edge` and increment in the same cycle: `mod_edge` wins and the increment is dropped.
- In NORMAL, the edit registers hold their last value. They are ignored downstream because both flags are low.

## Timing

- Reset: state NORMAL, all outputs 0, edit registers 0, all counters 0.
- A `mod_edge` sampled at clock edge k changes state and outputs at edge k; the outputs are visible in cycle k+1.
- An increment sampled at edge k updates `ore_setare`/`minute_setare` at edge k.
- `incarca_timp`:
  - Asserted for exactly one cycle (SCRIE_T).
  - During that cycle, `ore_setare`/`minute_setare` still hold the edited time and `semnal_setare` = 1.
  - The alarm values appear in the next cycle.
- `incarca_alarma` follows the same rule for the alarm, in SCRIE_A.
- Consecutive `mod_edge`s need a button release, so SCRIE states never see a `mod_edge`.
- A `reset` asserted mid-edit returns to NORMAL at that edge with no strobe.

## Test plan

Parameters for all cases: `REPEAT_DELAY`=4, `REPEAT_RATE`=2, `TIMEOUT`=20.

- Full sequence:
  - Stimulus: `ore`=23, `minute`=59, `ore_alarma`=6, `minute_alarma`=30. Pulse mod, inc, mod, inc, mod.
  - Response: `incarca_timp` high for 1 cycle with `ore_setare`=0, `minute_setare`=0. Next cycle the edit values are 6:30 and `semnal_setare_a`=1.
- Alarm commit:
  - Stimulus: continue with inc ×3, mod, inc, mod.
  - Response: `incarca_alarma` for 1 cycle with 9:31, then NORMAL with both flags 0.
- Auto-repeat:
  - Stimulus: in T_MIN from 10, hold `btn_inc` for 10 cycles.
  - Response: increments at edge, +4, +6, +8, giving `minute_setare`=14. Release stops further increments.
- Timeout:
  - Stimulus: enter T_ORE, then no buttons for 20 cycles.
  - Response: NORMAL, no strobe, flags 0.
- Simultaneous edges:
  - Stimulus: mod and inc edges in the same cycle in T_ORE.
  - Response: T_MIN reached, `ore_setare` unchanged.
- Reset cases:
  - Reset during A_MIN: all outputs 0 and no strobe.
  - `btn_mod` held high through reset release: no transition until it is released and pressed again.
